// File: rtl/hier_node_bcast.sv
// rtl/hier_node_bcast.sv - hierarchy node broadcasting one command to a child subset and aggregating completions
//
// Parameters:
//   NUM_CHILD  number of child channels (1..32)
//   DATA_W     command payload width
//   TIMEOUT    max COLLECT cycles before a forced response (1..65535)
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         upstream command handshake
//   in_data, in_mask          command payload and target children (bit i = child i)
//   ch_valid/ch_ready         per-child command handshake
//   ch_data                   latched payload, shared by all children
//   ch_done, ch_err           per-child completion pulse and error flag
//   out_valid/out_ready       aggregated response handshake
//   out_err_mask, out_timeout children that errored or timed out; response forced by timeout
//   busy                      node is not idle

module hier_node_bcast #(
  parameter int NUM_CHILD = 5,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [NUM_CHILD-1:0] in_mask,
  output logic [NUM_CHILD-1:0] ch_valid,
  input  logic [NUM_CHILD-1:0] ch_ready,
  output logic [DATA_W-1:0]    ch_data,
  input  logic [NUM_CHILD-1:0] ch_done,
  input  logic [NUM_CHILD-1:0] ch_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_CHILD-1:0] out_err_mask,
  output logic                 out_timeout,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [NUM_CHILD-1:0] pend_issue_q, pend_issue_d;
  logic [NUM_CHILD-1:0] pend_done_q, pend_done_d;
  logic [NUM_CHILD-1:0] err_q, err_d;
  logic [15:0]          tmo_cnt_q, tmo_cnt_d;
  logic                 tmo_q, tmo_d;
  // Holds in_ready low while rst is asserted without a path from rst itself.
  logic                 init_q;

  logic [NUM_CHILD-1:0] accept;
  logic [NUM_CHILD-1:0] done_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      pend_issue_q <= '0;
      pend_done_q  <= '0;
      err_q        <= '0;
      tmo_cnt_q    <= '0;
      tmo_q        <= 1'b0;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      pend_issue_q <= pend_issue_d;
      pend_done_q  <= pend_done_d;
      err_q        <= err_d;
      tmo_cnt_q    <= tmo_cnt_d;
      tmo_q        <= tmo_d;
      init_q       <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    pend_issue_d = pend_issue_q;
    pend_done_d  = pend_done_q;
    err_d        = err_q;
    tmo_cnt_d    = tmo_cnt_q;
    tmo_d        = tmo_q;
    accept       = '0;
    done_hit     = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          data_d       = in_data;
          pend_issue_d = in_mask;
          pend_done_d  = in_mask;
          err_d        = '0;
          tmo_cnt_d    = '0;
          tmo_d        = 1'b0;
          state_d      = (in_mask == '0) ? S_RESP : S_COLLECT;
        end
      end

      S_COLLECT: begin
        accept = pend_issue_q & ch_ready;
        // A done only counts once the child's command was accepted in an
        // earlier cycle, so a done alongside its own accept is dropped.
        done_hit     = ch_done & pend_done_q & ~pend_issue_q;
        pend_issue_d = pend_issue_q & ~accept;
        pend_done_d  = pend_done_q & ~done_hit;
        err_d        = err_q | (done_hit & ch_err);
        tmo_cnt_d    = tmo_cnt_q + 16'd1;
        if (pend_done_d == '0) begin
          state_d = S_RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Children still outstanding are reported as errored.
          err_d        = err_d | pend_done_d;
          tmo_d        = 1'b1;
          pend_issue_d = '0;
          pend_done_d  = '0;
          state_d      = S_RESP;
        end
      end

      S_RESP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready     = init_q && (state_q == S_IDLE);
  assign ch_valid     = (state_q == S_COLLECT) ? pend_issue_q : '0;
  assign ch_data      = data_q;
  assign out_valid    = (state_q == S_RESP);
  assign out_err_mask = (state_q == S_RESP) ? err_q : '0;
  assign out_timeout  = (state_q == S_RESP) && tmo_q;
  assign busy         = (state_q != S_IDLE);

endmodule
